// File: rtl/maze_move_checker_pkg.sv
// Shared constants and types for the maze move checker.
// Covers the map geometry, move directions, FSM states and open-mask bit positions.
package maze_pkg;

    localparam int COORD_W  = 5;
    localparam int ROW_BITS = 32;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_UP  = 3'd1,
        RD_MID = 3'd2,
        RD_DN  = 3'd3,
        RESP   = 3'd4
    } state_t;

    // Open-mask bit positions line up with the dir_t encoding so the mask can be indexed by direction
    localparam int OPEN_RIGHT = 0;
    localparam int OPEN_LEFT  = 1;
    localparam int OPEN_UP    = 2;
    localparam int OPEN_DOWN  = 3;

endpackage

// File: rtl/maze_move_checker_if.sv
// Request/response handshake plus the maze ROM row-lookup bus for the move checker.
// The slave modport is the checker; master is the actor logic together with the ROM.
interface maze_move_checker_if #(
    parameter int COORD_W  = 5,
    parameter int ROW_BITS = 32
);
    logic                req_valid;
    logic                req_ready;
    logic [COORD_W-1:0]  req_x;
    logic [COORD_W-1:0]  req_y;
    logic [1:0]          req_dir;

    logic [COORD_W-1:0]  map_row;
    logic [ROW_BITS-1:0] map_bits;

    logic                resp_valid;
    logic                resp_ready;
    logic [3:0]          resp_open;
    logic                resp_ok;
    logic                resp_cur_wall;
    logic [COORD_W-1:0]  resp_x;
    logic [COORD_W-1:0]  resp_y;

    modport slave (
        input  req_valid, req_x, req_y, req_dir, map_bits, resp_ready,
        output req_ready, map_row, resp_valid, resp_open, resp_ok,
               resp_cur_wall, resp_x, resp_y
    );

    modport master (
        output req_valid, req_x, req_y, req_dir, map_bits, resp_ready,
        input  req_ready, map_row, resp_valid, resp_open, resp_ok,
               resp_cur_wall, resp_x, resp_y
    );

endinterface

// File: rtl/maze_move_checker_cell_pick.sv
// Picks one cell out of a map row and reports whether it is a wall.
// Column 0 lives at the row MSB, so the bit index is ROW_BITS-1-col.
module maze_cell_pick #(
    parameter int COORD_W  = 5,
    parameter int ROW_BITS = 32,
    parameter bit WALL_VAL = 1'b1
) (
    input  logic [ROW_BITS-1:0] i_bits,
    input  logic [COORD_W-1:0]  i_col,
    output logic                o_wall
);

    logic [COORD_W-1:0] w_idx;

    assign w_idx  = COORD_W'(ROW_BITS - 1) - i_col;
    assign o_wall = (i_bits[w_idx] == WALL_VAL);

endmodule

// File: rtl/maze_move_checker.sv
// Reads the rows above, at and below a tile from the maze ROM and answers a move request
// with the open-neighbour mask, move legality and the resulting (wrapped) tile position.
module maze_move_checker #(
    parameter int COORD_W  = maze_pkg::COORD_W,
    parameter int ROW_BITS = maze_pkg::ROW_BITS,
    parameter bit WALL_VAL = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    maze_move_checker_if.slave   bus
);
    import maze_pkg::*;

    state_t             r_state;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    dir_t               r_dir;
    logic               r_up_wall;
    logic               r_left_wall;
    logic               r_right_wall;
    logic               r_cur_wall;

    logic               r_req_ready;
    logic               r_resp_valid;
    logic [3:0]         r_resp_open;
    logic               r_resp_ok;
    logic               r_resp_cur_wall;
    logic [COORD_W-1:0] r_resp_x;
    logic [COORD_W-1:0] r_resp_y;

    logic [COORD_W-1:0] w_x_dec;
    logic [COORD_W-1:0] w_x_inc;
    logic [COORD_W-1:0] w_y_dec;
    logic [COORD_W-1:0] w_y_inc;
    logic               w_wall_x;
    logic               w_wall_l;
    logic               w_wall_r;
    logic [COORD_W-1:0] w_map_row;
    logic [3:0]         w_open;
    logic               w_ok;
    logic [COORD_W-1:0] w_new_x;
    logic [COORD_W-1:0] w_new_y;

    // Plain modular arithmetic gives the tunnel wrap at both map edges
    assign w_x_dec = r_x - COORD_W'(1);
    assign w_x_inc = r_x + COORD_W'(1);
    assign w_y_dec = r_y - COORD_W'(1);
    assign w_y_inc = r_y + COORD_W'(1);

    maze_cell_pick #(.COORD_W(COORD_W), .ROW_BITS(ROW_BITS), .WALL_VAL(WALL_VAL)) u_pick_cur (
        .i_bits (bus.map_bits),
        .i_col  (r_x),
        .o_wall (w_wall_x)
    );

    maze_cell_pick #(.COORD_W(COORD_W), .ROW_BITS(ROW_BITS), .WALL_VAL(WALL_VAL)) u_pick_left (
        .i_bits (bus.map_bits),
        .i_col  (w_x_dec),
        .o_wall (w_wall_l)
    );

    maze_cell_pick #(.COORD_W(COORD_W), .ROW_BITS(ROW_BITS), .WALL_VAL(WALL_VAL)) u_pick_right (
        .i_bits (bus.map_bits),
        .i_col  (w_x_inc),
        .o_wall (w_wall_r)
    );

    always_comb begin
        w_map_row = '0;
        case (r_state)
            RD_UP:   w_map_row = w_y_dec;
            RD_MID:  w_map_row = r_y;
            RD_DN:   w_map_row = w_y_inc;
            default: w_map_row = '0;
        endcase
    end

    // The down bit is taken live from the ROM during RD_DN so the response lands on the same edge
    always_comb begin
        w_open             = '0;
        w_open[OPEN_RIGHT] = ~r_right_wall;
        w_open[OPEN_LEFT]  = ~r_left_wall;
        w_open[OPEN_UP]    = ~r_up_wall;
        w_open[OPEN_DOWN]  = ~w_wall_x;
        w_ok               = w_open[r_dir] & ~r_cur_wall;
        w_new_x            = r_x;
        w_new_y            = r_y;
        if (w_ok) begin
            case (r_dir)
                DIR_RIGHT: w_new_x = w_x_inc;
                DIR_LEFT:  w_new_x = w_x_dec;
                DIR_UP:    w_new_y = w_y_dec;
                DIR_DOWN:  w_new_y = w_y_inc;
                default:   w_new_x = r_x;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= IDLE;
            r_x             <= '0;
            r_y             <= '0;
            r_dir           <= DIR_RIGHT;
            r_up_wall       <= 1'b0;
            r_left_wall     <= 1'b0;
            r_right_wall    <= 1'b0;
            r_cur_wall      <= 1'b0;
            r_req_ready     <= 1'b1;
            r_resp_valid    <= 1'b0;
            r_resp_open     <= '0;
            r_resp_ok       <= 1'b0;
            r_resp_cur_wall <= 1'b0;
            r_resp_x        <= '0;
            r_resp_y        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_x         <= bus.req_x;
                        r_y         <= bus.req_y;
                        r_dir       <= dir_t'(bus.req_dir);
                        r_req_ready <= 1'b0;
                        r_state     <= RD_UP;
                    end
                end
                RD_UP: begin
                    r_up_wall <= w_wall_x;
                    r_state   <= RD_MID;
                end
                RD_MID: begin
                    r_left_wall  <= w_wall_l;
                    r_right_wall <= w_wall_r;
                    r_cur_wall   <= w_wall_x;
                    r_state      <= RD_DN;
                end
                RD_DN: begin
                    r_resp_open     <= w_open;
                    r_resp_ok       <= w_ok;
                    r_resp_cur_wall <= r_cur_wall;
                    r_resp_x        <= w_new_x;
                    r_resp_y        <= w_new_y;
                    r_resp_valid    <= 1'b1;
                    r_state         <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready     = r_req_ready;
    assign bus.map_row       = w_map_row;
    assign bus.resp_valid    = r_resp_valid;
    assign bus.resp_open     = r_resp_open;
    assign bus.resp_ok       = r_resp_ok;
    assign bus.resp_cur_wall = r_resp_cur_wall;
    assign bus.resp_x        = r_resp_x;
    assign bus.resp_y        = r_resp_y;

endmodule

// File: tb/tb_maze_move_checker.sv
// Self-checking bench for maze_move_checker: a ROM array answers row lookups, expected
// responses are queued when a request is accepted and compared when the response appears.
module tb_maze_move_checker;

    typedef struct packed {
        logic [3:0] open;
        logic       ok;
        logic       cur;
        logic [4:0] x;
        logic [4:0] y;
    } resp_t;

    logic        clk;
    logic        reset;
    logic [31:0] rom [0:31];
    resp_t       expQ [$];
    int          checkCount;
    int          errorCount;

    maze_move_checker_if #(.COORD_W(5), .ROW_BITS(32)) bus ();

    maze_move_checker dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    assign bus.map_bits = rom[bus.map_row];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic resp_t mkResp(input logic [3:0] open, input logic ok, input logic cur,
                                     input int x, input int y);
        resp_t r;
        r.open = open;
        r.ok   = ok;
        r.cur  = cur;
        r.x    = 5'(x);
        r.y    = 5'(y);
        return r;
    endfunction

    function automatic logic isWall(input int x, input int y);
        logic [31:0] row;
        row = rom[y & 31];
        return row[31 - (x & 31)];
    endfunction

    function automatic resp_t modelMove(input int x, input int y, input int d);
        logic [3:0] open;
        logic       cur;
        logic       ok;
        int         nx;
        int         ny;
        open[0] = !isWall(x + 1, y);
        open[1] = !isWall(x - 1, y);
        open[2] = !isWall(x, y - 1);
        open[3] = !isWall(x, y + 1);
        cur     = isWall(x, y);
        ok      = open[d] && !cur;
        nx      = x;
        ny      = y;
        if (ok) begin
            case (d)
                0: nx = x + 1;
                1: nx = x - 1;
                2: ny = y - 1;
                default: ny = y + 1;
            endcase
        end
        return mkResp(open, ok, cur, nx & 31, ny & 31);
    endfunction

    task automatic applyStimulus(input int x, input int y, input int d, input resp_t exp);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!bus.req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("reqReadyBeforeSend", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_x     = 5'(x);
        bus.req_y     = 5'(y);
        bus.req_dir   = 2'(d);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_x     = 5'($urandom);
        bus.req_y     = 5'($urandom);
        bus.req_dir   = 2'($urandom);
        expQ.push_back(exp);
    endtask

    task automatic checkReadSequence(input int y);
        @(negedge clk);
        checkOutput("mapRowUp", 32'(bus.map_row), 32'((y - 1) & 31));
        checkOutput("reqReadyBusy", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        checkOutput("mapRowMid", 32'(bus.map_row), 32'(y & 31));
        @(negedge clk);
        checkOutput("mapRowDown", 32'(bus.map_row), 32'((y + 1) & 31));
        checkOutput("respValidEarly", 32'(bus.resp_valid), 32'd0);
    endtask

    task automatic compareResp(input string tag, input resp_t exp);
        checkOutput({tag, "Open"}, 32'(bus.resp_open), 32'(exp.open));
        checkOutput({tag, "Ok"}, 32'(bus.resp_ok), 32'(exp.ok));
        checkOutput({tag, "CurWall"}, 32'(bus.resp_cur_wall), 32'(exp.cur));
        checkOutput({tag, "X"}, 32'(bus.resp_x), 32'(exp.x));
        checkOutput({tag, "Y"}, 32'(bus.resp_y), 32'(exp.y));
    endtask

    // Called right after the read sequence: the response must be visible at the very next sample.
    task automatic collectResponse(input int holdCycles);
        int    waited;
        resp_t exp;
        waited = 0;
        @(negedge clk);
        while (!bus.resp_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("respLatency", 32'(waited), 32'd0);
        if (expQ.size() == 0) begin
            checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd1);
            return;
        end
        exp = expQ.pop_front();
        compareResp("resp", exp);
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            checkOutput("holdValid", 32'(bus.resp_valid), 32'd1);
            checkOutput("holdReqReady", 32'(bus.req_ready), 32'd0);
            compareResp("hold", exp);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        checkCount     = 0;
        errorCount     = 0;
        reset          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_x      = '0;
        bus.req_y      = '0;
        bus.req_dir    = '0;
        bus.resp_ready = 1'b0;
        for (int r = 0; r < 32; r++) rom[r] = 32'h0;
        rom[1] = 32'hFFFF_FFFF;
        rom[2] = 32'b11000000000000110000000000001111;
        rom[3] = 32'b11011110111110110111110111101111;
        rom[5] = 32'b11011110111110110111110111101111;
        rom[6] = 32'b11000000000000000000000000001111;
        rom[7] = 32'b11011110110111111110110111101111;

        repeat (3) @(negedge clk);
        checkOutput("rstReqReady", 32'(bus.req_ready), 32'd1);
        checkOutput("rstMapRow", 32'(bus.map_row), 32'd0);
        checkOutput("rstRespValid", 32'(bus.resp_valid), 32'd0);
        compareResp("rst", mkResp(4'b0000, 1'b0, 1'b0, 0, 0));
        reset = 1'b1;

        $display("[TB] move right from (2,2)");
        applyStimulus(2, 2, 0, mkResp(4'b1001, 1'b1, 1'b0, 3, 2));
        checkReadSequence(2);
        collectResponse(0);

        $display("[TB] move up from (2,2) into a wall");
        applyStimulus(2, 2, 2, mkResp(4'b1001, 1'b0, 1'b0, 2, 2));
        checkReadSequence(2);
        collectResponse(0);

        $display("[TB] move down from (10,6) under backpressure with a queued second request");
        applyStimulus(10, 6, 3, mkResp(4'b1011, 1'b1, 1'b0, 10, 7));
        checkReadSequence(6);
        bus.req_valid = 1'b1;
        bus.req_x     = 5'd2;
        bus.req_y     = 5'd2;
        bus.req_dir   = 2'd0;
        collectResponse(6);
        @(negedge clk);
        checkOutput("afterHsReqReady", 32'(bus.req_ready), 32'd1);
        checkOutput("afterHsRespValid", 32'(bus.resp_valid), 32'd0);
        checkOutput("afterHsMapRow", 32'(bus.map_row), 32'd0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        expQ.push_back(mkResp(4'b1001, 1'b1, 1'b0, 3, 2));
        checkReadSequence(2);
        collectResponse(0);

        $display("[TB] wrap-around move left from (0,0)");
        rom[0]  = 32'hFFFF_FFFF;
        rom[31] = 32'hFFFF_FFFF;
        applyStimulus(0, 0, 1, mkResp(4'b0000, 1'b0, 1'b1, 0, 0));
        checkReadSequence(0);
        collectResponse(0);

        $display("[TB] reset pulse in the middle of a read");
        applyStimulus(10, 6, 3, mkResp(4'b1011, 1'b1, 1'b0, 10, 7));
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midRstReqReady", 32'(bus.req_ready), 32'd1);
        checkOutput("midRstMapRow", 32'(bus.map_row), 32'd0);
        checkOutput("midRstRespValid", 32'(bus.resp_valid), 32'd0);
        void'(expQ.pop_back());
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("abortNoResp", 32'(bus.resp_valid), 32'd0);
        end
        applyStimulus(10, 6, 3, mkResp(4'b1011, 1'b1, 1'b0, 10, 7));
        checkReadSequence(6);
        collectResponse(0);

        $display("[TB] random maze, model-predicted moves");
        for (int r = 0; r < 32; r++) rom[r] = $urandom;
        for (int n = 0; n < 12; n++) begin
            int x;
            int y;
            int d;
            case (n)
                0:       begin x = 31; y = 31; d = 3; end
                1:       begin x = 31; y = 7;  d = 0; end
                2:       begin x = 0;  y = 0;  d = 2; end
                3:       begin x = 0;  y = 9;  d = 1; end
                default: begin x = $urandom_range(0, 31); y = $urandom_range(0, 31); d = $urandom_range(0, 3); end
            endcase
            applyStimulus(x, y, d, modelMove(x, y, d));
            checkReadSequence(y);
            collectResponse(n % 3);
        end

        checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
